// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and registered forwarding selects.
// The forwarding decision is made in ID so EX sees a ready mux select on the cycle it executes.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_uses_rt,
  input  logic [31:0] id_read_data1,
  input  logic [31:0] id_read_data2,
  input  logic [31:0] id_imm,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_mem_to_reg,
  input  logic        id_alu_src,
  input  logic        id_reg_dst,
  input  logic [3:0]  id_alu_op,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_write_reg,
  output logic        stall,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg,
  output logic        ex_alu_src,
  output logic [3:0]  ex_alu_op,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_write_reg,
  output logic [31:0] ex_read_data1,
  output logic [31:0] ex_read_data2,
  output logic [31:0] ex_imm,
  output logic [1:0]  ex_forward_a,
  output logic [1:0]  ex_forward_b,
  output logic [15:0] stall_count
);

  logic        r_valid;
  logic        r_reg_write;
  logic        r_mem_read;
  logic        r_mem_write;
  logic        r_mem_to_reg;
  logic        r_alu_src;
  logic [3:0]  r_alu_op;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [4:0]  r_write_reg;
  logic [31:0] r_read_data1;
  logic [31:0] r_read_data2;
  logic [31:0] r_imm;
  logic [1:0]  r_fwd_a;
  logic [1:0]  r_fwd_b;
  logic [15:0] r_stall_count;

  logic [4:0]  w_wr;
  logic        w_stall;
  logic        w_bubble;
  logic        w_ex_fwd_a;
  logic        w_ex_fwd_b;
  logic        w_mem_fwd_a;
  logic        w_mem_fwd_b;
  logic [1:0]  w_fwd_a;
  logic [1:0]  w_fwd_b;

  assign w_wr = id_reg_dst ? id_rd : id_rt;

  // Load in EX whose destination ID needs: hold ID one cycle so the load reaches MEM.
  assign w_stall = r_valid & r_mem_read & (r_write_reg != 5'd0) &
                   ((id_rs == r_write_reg) | (id_uses_rt & (id_rt == r_write_reg))) &
                   id_valid & ~flush;
  assign w_bubble = flush | w_stall;

  // EX-stage producer is younger than MEM-stage, so it takes priority.
  assign w_ex_fwd_a  = r_valid & r_reg_write & (r_write_reg != 5'd0) & (r_write_reg == id_rs);
  assign w_ex_fwd_b  = r_valid & r_reg_write & (r_write_reg != 5'd0) & (r_write_reg == id_rt);
  assign w_mem_fwd_a = mem_reg_write & (mem_write_reg != 5'd0) & (mem_write_reg == id_rs);
  assign w_mem_fwd_b = mem_reg_write & (mem_write_reg != 5'd0) & (mem_write_reg == id_rt);
  assign w_fwd_a = w_ex_fwd_a ? 2'b10 : (w_mem_fwd_a ? 2'b01 : 2'b00);
  assign w_fwd_b = w_ex_fwd_b ? 2'b10 : (w_mem_fwd_b ? 2'b01 : 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid       <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_alu_src     <= 1'b0;
      r_alu_op      <= 4'd0;
      r_rs          <= 5'd0;
      r_rt          <= 5'd0;
      r_write_reg   <= 5'd0;
      r_read_data1  <= 32'd0;
      r_read_data2  <= 32'd0;
      r_imm         <= 32'd0;
      r_fwd_a       <= 2'b00;
      r_fwd_b       <= 2'b00;
      r_stall_count <= 16'd0;
    end else begin
      if (w_bubble) begin
        r_valid      <= 1'b0;
        r_reg_write  <= 1'b0;
        r_mem_read   <= 1'b0;
        r_mem_write  <= 1'b0;
        r_mem_to_reg <= 1'b0;
        r_alu_src    <= 1'b0;
        r_alu_op     <= 4'd0;
        r_fwd_a      <= 2'b00;
        r_fwd_b      <= 2'b00;
      end else begin
        r_valid      <= id_valid;
        r_reg_write  <= id_valid & id_reg_write;
        r_mem_read   <= id_valid & id_mem_read;
        r_mem_write  <= id_valid & id_mem_write;
        r_mem_to_reg <= id_valid & id_mem_to_reg;
        r_alu_src    <= id_valid & id_alu_src;
        r_alu_op     <= id_valid ? id_alu_op : 4'd0;
        r_fwd_a      <= id_valid ? w_fwd_a : 2'b00;
        r_fwd_b      <= id_valid ? w_fwd_b : 2'b00;
      end
      // Data and specifiers are don't-care in a bubble, so they load unconditionally.
      r_rs         <= id_rs;
      r_rt         <= id_rt;
      r_write_reg  <= w_wr;
      r_read_data1 <= id_read_data1;
      r_read_data2 <= id_read_data2;
      r_imm        <= id_imm;
      if (w_stall && (r_stall_count != 16'hFFFF))
        r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall         = w_stall;
  assign ex_valid      = r_valid;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_mem_to_reg = r_mem_to_reg;
  assign ex_alu_src    = r_alu_src;
  assign ex_alu_op     = r_alu_op;
  assign ex_rs         = r_rs;
  assign ex_rt         = r_rt;
  assign ex_write_reg  = r_write_reg;
  assign ex_read_data1 = r_read_data1;
  assign ex_read_data2 = r_read_data2;
  assign ex_imm        = r_imm;
  assign ex_forward_a  = r_fwd_a;
  assign ex_forward_b  = r_fwd_b;
  assign stall_count   = r_stall_count;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have exactly one clock and one reset: clock port clk (rising edge); reset port rst, asynchronous, active-high.
REQ-002 clk  in  1  pipeline clock.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 flush  in  1  branch/jump taken; squash the ID instruction.
REQ-005 id_valid  in  1  ID holds a real instruction.
REQ-006 id_rs, id_rt, id_rd  in  5 each  ID register specifiers.
REQ-007 id_uses_rt  in  1  ID instruction reads rt (R-type, store, branch).
REQ-008 id_read_data1, id_read_data2, id_imm  in  32 each  ID operands, sign-extended immediate.
REQ-009 id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst  in  1 each  ID control.
REQ-010 id_alu_op  in  4  ALU operation.
REQ-011 mem_reg_write  in  1, mem_write_reg  in  5  destination of the instruction currently in MEM.
REQ-012 stall  out  1  combinational load-use hazard; freezes PC and IF/ID.
REQ-013 ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src  out  1 each  registered EX control.
REQ-014 ex_alu_op  out  4; ex_rs, ex_rt, ex_write_reg  out  5 each; ex_read_data1, ex_read_data2, ex_imm  out  32 each  registered EX fields.
REQ-015 ex_forward_a, ex_forward_b  out  2 each  registered select for the EX operand 3:1 muxes: 00 register file, 01 MEM/WB result, 10 EX/MEM ALU result; 11 never driven.
REQ-016 stall_count  out  16  saturating count of load-use stall cycles.

Function
REQ-017 Write-register select SHALL be computed in ID: wr = id_reg_dst ? id_rd : id_rt; captured into ex_write_reg.
REQ-018 stall SHALL be 1 iff ex_valid & ex_mem_read & ex_write_reg!=0 & (id_rs==ex_write_reg | (id_uses_rt & id_rt==ex_write_reg)) & id_valid & !flush.
REQ-019 Each rising edge, priority flush > stall > load: flush or stall SHALL load a bubble (ex_valid and all six control bits 0, ex_alu_op 0, ex_forward_a/b 00, data/specifier fields don't-care); otherwise all ID fields SHALL load, ex_valid = id_valid.
REQ-020 id_valid=0 SHALL load with all control bits forced 0.
REQ-021 Next ex_forward_a SHALL be 10 if ex_valid & ex_reg_write & ex_write_reg!=0 & ex_write_reg==id_rs; else 01 if mem_reg_write & mem_write_reg!=0 & mem_write_reg==id_rs; else 00 (EX-stage match wins over MEM-stage match).
REQ-022 ex_forward_b SHALL follow REQ-021 using id_rt, independent of id_uses_rt.
REQ-023 Register 0 SHALL never produce forwarding or stall.
REQ-024 Latency SHALL be one cycle ID to EX; no other internal state beyond the EX register and stall_count.
REQ-025 stall_count SHALL increment by 1 on each edge where stall=1 and flush=0, saturating at 16'hFFFF with no wrap.
REQ-026 A load-use dependency SHALL cause exactly one stall cycle; the following cycle SHALL select 01 for the dependent operand.

Reset
REQ-027 rst=1 SHALL immediately, independent of clk, clear every registered output to 0 (bubble state, forward selects 00, stall_count 0).
REQ-028 rst asserted mid-stall SHALL clear stall_count and bubble EX; stall SHALL then evaluate from the cleared EX (0).
REQ-029 Release of rst SHALL take effect at the next rising edge with no extra wait cycles.

Verification
REQ-030 Reset: rst=1 asynchronously between edges -> all outputs 0 before next edge; stall_count=0.
REQ-031 EX forward: EX add $3 (reg_write=1), ID rs=3, rt=4; MEM writes $4 -> next edge ex_forward_a=10, ex_forward_b=01.
REQ-032 Double match: EX and MEM both write $5, ID rs=5 -> ex_forward_a=10; target $0 in both -> 00.
REQ-033 Load-use: EX lw $8, ID add rs=8 -> stall=1 one cycle, EX bubble (ex_valid=0), stall_count=1; next cycle stall=0, lw in MEM, add loads with ex_forward_a=01.
REQ-034 Flush during stall: EX lw $8, ID rs=8, flush=1 -> stall=0, bubble loaded, stall_count unchanged.
REQ-035 Saturation: preload stall_count to 16'hFFFE, force three stall cycles -> count reads FFFF and holds.
